// File: rtl/multicycle_control_p.sv
// Control FSM for the multicycle datapath: sequences fetch/decode/execute/writeback,
// drives the mux selects and write enables, and counts retired instructions.
module multicycle_control_p #(
   parameter int OPCODE_W = 4,
   parameter int CNT_W    = 16,
   parameter bit MEM_WAIT = 1'b1
) (
   input  logic                CLK,
   input  logic                Reset,
   input  logic [OPCODE_W-1:0] Opcode,
   input  logic                mem_ready,
   input  logic                stall,
   output logic                PCWriteCond,
   output logic                PCWrite,
   output logic                IorD,
   output logic                IRWrite,
   output logic                ALUSrcA,
   output logic [1:0]          ALUSrcB,
   output logic                ALUOp,
   output logic [1:0]          ImmgenOp,
   output logic                RegWrite,
   output logic                PCSrc,
   output logic                MemWrite,
   output logic                MemRead,
   output logic [1:0]          MemToReg,
   output logic [4:0]          current_state,
   output logic [4:0]          next_state,
   output logic                illegal_op,
   output logic                instr_done,
   output logic [CNT_W-1:0]    instret
);

   typedef enum logic [4:0] {
      FETCH    = 5'd0,
      DECODE   = 5'd1,
      EXE_ADD  = 5'd2,
      EXE_SUB  = 5'd3,
      WB_ALU   = 5'd4,
      WB_POS   = 5'd5,
      WB_ZERO  = 5'd6,
      EXE_JAL  = 5'd7,
      EXE_JALR = 5'd8,
      WB_JUMP  = 5'd9,
      MEM_ADDR = 5'd11,
      MEM_RD   = 5'd12,
      MEM_WR   = 5'd13,
      WB_MEM   = 5'd14,
      TRAP     = 5'd15
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] instret_q;
   logic             rdy;
   logic             op_hi;
   logic [3:0]       op;
   logic             wen_ok;
   logic             pc_write_raw, ir_write_raw, reg_write_raw, mem_write_raw;

   assign rdy = MEM_WAIT ? mem_ready : 1'b1;
   assign op  = Opcode[3:0];

   // Any set bit above the 4-bit opcode field marks the instruction illegal.
   generate
      if (OPCODE_W > 4) begin : g_wide_op
         assign op_hi = |Opcode[OPCODE_W-1:4];
      end else begin : g_narrow_op
         assign op_hi = 1'b0;
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:    state_d = rdy ? DECODE : FETCH;
         DECODE: begin
            if (op_hi) begin
               state_d = TRAP;
            end else begin
               case (op)
                  4'd0:             state_d = EXE_ADD;
                  4'd1, 4'd2, 4'd3: state_d = EXE_SUB;
                  4'd4:             state_d = EXE_JALR;
                  4'd6:             state_d = EXE_JAL;
                  4'd8, 4'd9:       state_d = MEM_ADDR;
                  default:          state_d = TRAP;
               endcase
            end
         end
         EXE_ADD:  state_d = WB_ALU;
         EXE_SUB: begin
            case (op)
               4'd1:    state_d = WB_POS;
               4'd3:    state_d = WB_ZERO;
               default: state_d = WB_ALU;
            endcase
         end
         EXE_JAL, EXE_JALR: state_d = WB_JUMP;
         MEM_ADDR: state_d = (op == 4'd9) ? MEM_WR : MEM_RD;
         MEM_RD:   state_d = rdy ? WB_MEM : MEM_RD;
         MEM_WR:   state_d = rdy ? FETCH : MEM_WR;
         WB_ALU, WB_POS, WB_ZERO, WB_JUMP, WB_MEM: state_d = FETCH;
         TRAP:     state_d = TRAP;
         default:  state_d = FETCH;
      endcase
      // A stall freezes the FSM, discarding any concurrent memory ready.
      if (stall) begin
         state_d = state_q;
      end
   end

   always_comb begin
      PCWriteCond   = 1'b0;
      IorD          = 1'b0;
      ALUSrcA       = 1'b0;
      ALUSrcB       = 2'b00;
      ALUOp         = 1'b0;
      ImmgenOp      = 2'b00;
      PCSrc         = 1'b0;
      MemRead       = 1'b0;
      MemToReg      = 2'b00;
      illegal_op    = 1'b0;
      pc_write_raw  = 1'b0;
      ir_write_raw  = 1'b0;
      reg_write_raw = 1'b0;
      mem_write_raw = 1'b0;
      case (state_q)
         FETCH: begin
            MemRead      = 1'b1;
            ALUSrcB      = 2'b01;
            ir_write_raw = rdy;
            pc_write_raw = rdy;
         end
         EXE_ADD:  ALUSrcA = 1'b1;
         EXE_SUB: begin
            ALUSrcA = 1'b1;
            ALUOp   = 1'b1;
         end
         WB_ALU:  reg_write_raw = 1'b1;
         WB_POS: begin
            reg_write_raw = 1'b1;
            MemToReg      = 2'b11;
         end
         WB_ZERO: begin
            reg_write_raw = 1'b1;
            MemToReg      = 2'b10;
         end
         EXE_JAL: ALUSrcB = 2'b10;
         EXE_JALR, MEM_ADDR: begin
            ALUSrcA  = 1'b1;
            ALUSrcB  = 2'b10;
            ImmgenOp = 2'b10;
         end
         WB_JUMP: begin
            pc_write_raw = 1'b1;
            PCSrc        = 1'b1;
         end
         MEM_RD: begin
            IorD    = 1'b1;
            MemRead = 1'b1;
         end
         MEM_WR: begin
            IorD          = 1'b1;
            mem_write_raw = rdy;
         end
         WB_MEM: begin
            reg_write_raw = 1'b1;
            MemToReg      = 2'b01;
         end
         TRAP:    illegal_op = 1'b1;
         default: ;
      endcase
   end

   // Reset and stall gate every write enable combinationally so nothing glitches high.
   assign wen_ok     = !stall && !Reset;
   assign PCWrite    = pc_write_raw  && wen_ok;
   assign IRWrite    = ir_write_raw  && wen_ok;
   assign RegWrite   = reg_write_raw && wen_ok;
   assign MemWrite   = mem_write_raw && wen_ok;
   assign instr_done = (state_q != FETCH) && (state_d == FETCH) && wen_ok;

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q   <= FETCH;
         instret_q <= '0;
      end else begin
         state_q <= state_d;
         if (instr_done) begin
            instret_q <= instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign current_state = state_q;
   assign next_state    = state_d;
   assign instret       = instret_q;

endmodule
